// File: rtl/dsm_sample_feeder.sv
// dsm_sample_feeder
// Sample scheduler in front of the 2nd-order delta-sigma modulator.
// Buffers unsigned 16-bit PCM from an upstream valid/ready stream in a FIFO
// and hands one sample to the modulator on each pull strobe. It waits for
// PRIME_LEVEL samples before it starts, mutes to MUTE_CODE on underrun and
// keeps a saturating underrun count. enable=0 mutes and flushes everything.

module dsm_sample_feeder #(
    parameter int          DEPTH       = 16,
    parameter int          PRIME_LEVEL = 8,
    parameter logic [15:0] MUTE_CODE   = 16'h8000,
    parameter int          CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     pull,
    output logic [15:0]              samp,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     running,
    output logic [CNT_W-1:0]         underrun_cnt
);

    // Address width indexes the storage; the extra pointer/level bit lets a
    // full FIFO (level == DEPTH) be told apart from an empty one.
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]    LVL_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0]    LVL_ONE   = LW'(1);
    localparam logic [LW-1:0]    LVL_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_PRIME = LW'(PRIME_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [15:0]        mem_r [DEPTH];
    logic [LW-1:0]      wr_ptr_r;
    logic [LW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic [LW-1:0]      level_next_s;
    logic [15:0]        samp_r;
    logic [15:0]        samp_next_s;
    logic               in_ready_r;
    logic               running_r;
    logic [CNT_W-1:0]   ucnt_r;

    logic               flush_s;
    logic               push_s;
    logic               pop_s;
    logic               uflow_s;
    logic               empty_s;

    // FIFO is empty when both pointers (including the wrap bit) coincide.
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // While disabled or idle the FIFO is held empty and samp is forced mute.
    assign flush_s = (~enable) | (state_r == ST_IDLE);

    // A push needs the registered ready; a push in a disable cycle is dropped
    // because the flush wins.
    assign push_s = in_valid & in_ready_r & enable;

    // Next-state decode; also decides whether this pull pops or underruns.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        uflow_s      = 1'b0;
        if (!enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // pull is ignored here; the FIFO opens next cycle
                    state_next_s = ST_PRIME;
                end
                ST_PRIME: begin
                    if (pull && (level_r >= LVL_PRIME)) begin
                        pop_s        = 1'b1;
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    if (pull) begin
                        if (!empty_s) begin
                            pop_s        = 1'b1;
                            state_next_s = ST_RUN;
                        end else begin
                            uflow_s      = 1'b1;
                            state_next_s = ST_PRIME;
                        end
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Occupancy after this cycle's push/pop; a flush overrides both.
    always_comb begin
        level_next_s = level_r;
        if (flush_s) begin
            level_next_s = LVL_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_next_s = level_r + LVL_ONE;
                2'b01:   level_next_s = level_r - LVL_ONE;
                default: level_next_s = level_r;
            endcase
        end
    end

    // Value the modulator sees after this edge: head on pop, mute on flush or underrun.
    always_comb begin
        samp_next_s = samp_r;
        if (flush_s) begin
            samp_next_s = MUTE_CODE;
        end else if (pop_s) begin
            samp_next_s = mem_r[rd_ptr_r[AW-1:0]];
        end else if (uflow_s) begin
            samp_next_s = MUTE_CODE;
        end else begin
            samp_next_s = samp_r;
        end
    end

    // State, sample and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            samp_r     <= MUTE_CODE;
            level_r    <= LVL_ZERO;
            in_ready_r <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            samp_r     <= samp_next_s;
            level_r    <= level_next_s;
            in_ready_r <= (state_next_s != ST_IDLE) && (level_next_s < LVL_DEPTH);
            running_r  <= (state_next_s == ST_RUN);
        end
    end

    // Read/write pointers; they wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= LVL_ZERO;
            rd_ptr_r <= LVL_ZERO;
        end else if (flush_s) begin
            wr_ptr_r <= LVL_ZERO;
            rd_ptr_r <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + LVL_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + LVL_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Sample storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= in_data;
        end
    end

    // Saturating underrun counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_r <= {CNT_W{1'b0}};
        end else if (uflow_s && (ucnt_r != CNT_MAX)) begin
            ucnt_r <= ucnt_r + CNT_ONE;
        end else begin
            ucnt_r <= ucnt_r;
        end
    end

    assign in_ready     = in_ready_r;
    assign samp         = samp_r;
    assign level        = level_r;
    assign running      = running_r;
    assign underrun_cnt = ucnt_r;

endmodule
